// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose: main control FSM for a multicycle MIPS-style datapath. This is a
// Moore machine: every datapath control decodes from the state register. The
// exceptions are pc_en and IRWrite, which also qualify on mem_ready (FETCH) or
// zero (BRANCH). DECODE latches the opcode, and later states use only that
// latched copy, so the IR may change freely after DECODE.
//
// Optional feature: define MULTICYCLE_JUMP_EN to enable the J instruction
// (opcode 000010 -> JUMP state). When it is undefined, 000010 is illegal and
// PCSource never takes the value 10.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   [5:0] IR[31:26], sampled in DECODE
//   zero       in   ALU zero flag, used in BRANCH
//   mem_ready  in   memory done (read data valid / write accepted)
//   pc_en      out  PC load enable
//   IorD       out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead    out  memory read request
//   MemWrite   out  memory write request
//   IRWrite    out  instruction register load
//   RegDest    out  register write address select: 1 = rd, 0 = rt
//   MemtoReg   out  register write data select: 1 = MDR, 0 = ALUOut
//   RegWrite   out  register file write enable
//   ALUSrcA    out  ALU A select: 0 = PC, 1 = rs
//   ALUSrcB    out  [1:0] ALU B select: 00 rt, 01 4, 10 sext imm, 11 shifted imm
//   ALUOp      out  [2:0] 000 add, 001 sub, 010 funct, 100 addi, 101 andi, 111 ori
//   PCSource   out  [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   state      out  [3:0] current state code (debug)
//   illegal    out  one-cycle pulse in DECODE on an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDest,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StExecI  = 4'd9,
    StIwb    = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OpJ     = 6'b000010;
`endif

  state_e     r_state;
  logic [5:0] r_opcode;
  // Cleared by reset and set on the first clock after release; keeps every
  // output at 0 until that edge so the first FETCH starts on a clean edge.
  logic       r_active;

  state_e     w_dec_next;
  logic       w_dec_illegal;

  // DECODE dispatch on the live opcode (the latch is loaded on this same edge).
  always_comb begin
    w_dec_next    = StFetch;
    w_dec_illegal = 1'b0;
    case (opcode)
      OpRType:                w_dec_next = StExecR;
      OpLw, OpSw:             w_dec_next = StMemAdr;
      OpBeq, OpBne:           w_dec_next = StBranch;
      OpAddi, OpAndi, OpOri:  w_dec_next = StExecI;
`ifdef MULTICYCLE_JUMP_EN
      OpJ:                    w_dec_next = StJump;
`endif
      default:                w_dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StFetch;
      r_opcode <= 6'd0;
      r_active <= 1'b0;
    end else if (!r_active) begin
      r_active <= 1'b1;
    end else begin
      case (r_state)
        StFetch: begin
          if (mem_ready) r_state <= StDecode;
        end
        StDecode: begin
          r_opcode <= opcode;
          r_state  <= w_dec_next;
        end
        StMemAdr: r_state <= (r_opcode == OpSw) ? StMemWr : StMemRd;
        StMemRd: begin
          if (mem_ready) r_state <= StMemWb;
        end
        StMemWb:  r_state <= StFetch;
        StMemWr: begin
          if (mem_ready) r_state <= StFetch;
        end
        StExecR:  r_state <= StRwb;
        StRwb:    r_state <= StFetch;
        StBranch: r_state <= StFetch;
        StExecI:  r_state <= StIwb;
        StIwb:    r_state <= StFetch;
`ifdef MULTICYCLE_JUMP_EN
        StJump:   r_state <= StFetch;
`endif
        // Unused codes (and JUMP when the feature is off) recover to FETCH.
        default:  r_state <= StFetch;
      endcase
    end
  end

  always_comb begin
    pc_en    = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDest  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 3'b000;
    PCSource = 2'b00;
    state    = 4'd0;
    illegal  = 1'b0;
    if (r_active) begin
      state = r_state;
      case (r_state)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          pc_en   = mem_ready;
        end
        StDecode: begin
          ALUSrcB = 2'b11;
          illegal = w_dec_illegal;
        end
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        StMemWr: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        StExecR: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        StRwb: begin
          RegWrite = 1'b1;
          RegDest  = 1'b1;
        end
        StBranch: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 3'b001;
          PCSource = 2'b01;
          pc_en    = (r_opcode == OpBne) ? ~zero : zero;
        end
        StExecI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (r_opcode)
            OpAndi:  ALUOp = 3'b101;
            OpOri:   ALUOp = 3'b111;
            default: ALUOp = 3'b100;
          endcase
        end
        StIwb: begin
          RegWrite = 1'b1;
        end
`ifdef MULTICYCLE_JUMP_EN
        StJump: begin
          pc_en    = 1'b1;
          PCSource = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
